// File: rtl/clint_pkg.sv
// Shared address map, reset constants and byte-lane merge helper for the CLINT.
package clint_pkg;

   localparam logic [15:0] MSIP_BASE      = 16'h0000;
   localparam logic [15:0] MTIMECMP_BASE  = 16'h4000;
   localparam logic [15:0] MTIME_OFFSET   = 16'hBFF8;
   localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

   // Replace only the byte lanes whose enable bit is set.
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  mask);
      logic [31:0] r;
      r = old_val;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) r[8*i +: 8] = new_val[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Divides clk down to a one-cycle mtime tick every DIVIDER cycles; clear restarts the count.
// Tick is combinational from the count register; no backpressure.
module clint_prescaler #(
   parameter int DIVIDER = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int          CW   = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

   logic [CW-1:0] cnt_q;

   assign tick = (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: mtime counter, per-hart mtimecmp/msip, registered timer irqs.
// Reads are combinational, writes take effect on the next edge, irqs lag state by one cycle.
module clint
   import clint_pkg::*;
#(
   parameter int NUM_HARTS = 1,
   parameter int DIVIDER   = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          address_in,
   input  logic                 sel_in,
   input  logic                 read_in,
   output logic [31:0]          read_value_out,
   input  logic [3:0]           write_mask_in,
   input  logic [31:0]          write_value_in,
   output logic [NUM_HARTS-1:0] timer_irq_out,
   output logic [NUM_HARTS-1:0] soft_irq_out
);

   localparam logic [13:0] MSIP_W     = MSIP_BASE[15:2];
   localparam logic [13:0] CMP_W      = MTIMECMP_BASE[15:2];
   localparam logic [13:0] MTIME_LO_W = MTIME_OFFSET[15:2];
   localparam logic [13:0] MTIME_HI_W = MTIME_LO_W + 14'd1;

   logic [13:0]                 word;
   logic                        wr_en;
   logic                        mtime_lo_wr;
   logic                        mtime_hi_wr;
   logic                        tick;
   logic [63:0]                 mtime_q;
   logic [NUM_HARTS-1:0]        msip_q;
   logic [NUM_HARTS-1:0][63:0]  mtimecmp;
   logic                        unused_bits;

   assign word        = address_in[15:2];
   assign wr_en       = sel_in && (write_mask_in != 4'b0);
   assign mtime_lo_wr = wr_en && (word == MTIME_LO_W);
   assign mtime_hi_wr = wr_en && (word == MTIME_HI_W);
   assign unused_bits = ^{read_in, address_in[31:16], address_in[1:0]};

   clint_prescaler #(.DIVIDER(DIVIDER)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clear (mtime_lo_wr || mtime_hi_wr),
      .tick  (tick)
   );

   // A bus write to mtime replaces the increment for that cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         mtime_q <= '0;
      end else if (mtime_lo_wr) begin
         mtime_q[31:0] <= merge_lanes(mtime_q[31:0], write_value_in, write_mask_in);
      end else if (mtime_hi_wr) begin
         mtime_q[63:32] <= merge_lanes(mtime_q[63:32], write_value_in, write_mask_in);
      end else if (tick) begin
         mtime_q <= mtime_q + 64'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         msip_q <= '0;
      end else begin
         for (int h = 0; h < NUM_HARTS; h++) begin
            if (wr_en && write_mask_in[0] && (word == MSIP_W + 14'(h))) begin
               msip_q[h] <= write_value_in[0];
            end
         end
      end
   end

   assign soft_irq_out = msip_q;

   for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
      logic [63:0] cmp_q;
      logic        irq_q;
      logic        lo_wr;
      logic        hi_wr;

      assign lo_wr = wr_en && (word == CMP_W + 14'(2 * h));
      assign hi_wr = wr_en && (word == CMP_W + 14'(2 * h + 1));

      always_ff @(posedge clk) begin
         if (reset) begin
            cmp_q <= MTIMECMP_RESET;
            irq_q <= 1'b0;
         end else begin
            if (lo_wr) cmp_q[31:0]  <= merge_lanes(cmp_q[31:0], write_value_in, write_mask_in);
            if (hi_wr) cmp_q[63:32] <= merge_lanes(cmp_q[63:32], write_value_in, write_mask_in);
            irq_q <= (mtime_q >= cmp_q);
         end
      end

      assign mtimecmp[h]      = cmp_q;
      assign timer_irq_out[h] = irq_q;
   end

   always_comb begin
      read_value_out = '0;
      if (sel_in) begin
         if (word == MTIME_LO_W) read_value_out = mtime_q[31:0];
         if (word == MTIME_HI_W) read_value_out = mtime_q[63:32];
         for (int h = 0; h < NUM_HARTS; h++) begin
            if (word == MSIP_W + 14'(h))        read_value_out = {31'b0, msip_q[h]};
            if (word == CMP_W + 14'(2 * h))     read_value_out = mtimecmp[h][31:0];
            if (word == CMP_W + 14'(2 * h + 1)) read_value_out = mtimecmp[h][63:32];
         end
      end
   end

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint (2 harts, divide-by-4) with a per-cycle reference model.
module tb_clint;

   localparam int NH  = 2;
   localparam int DIV = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [31:0]   address_in = '0;
   logic          sel_in = 1'b0;
   logic          read_in = 1'b0;
   logic [31:0]   read_value_out;
   logic [3:0]    write_mask_in = '0;
   logic [31:0]   write_value_in = '0;
   logic [NH-1:0] timer_irq_out;
   logic [NH-1:0] soft_irq_out;

   int asserts = 0;
   int fails   = 0;

   clint #(.NUM_HARTS(NH), .DIVIDER(DIV)) dut (
      .clk            (clk),
      .reset          (reset),
      .address_in     (address_in),
      .sel_in         (sel_in),
      .read_in        (read_in),
      .read_value_out (read_value_out),
      .write_mask_in  (write_mask_in),
      .write_value_in (write_value_in),
      .timer_irq_out  (timer_irq_out),
      .soft_irq_out   (soft_irq_out)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [63:0] m_mtime;
   int          m_presc;
   logic [63:0] m_cmp [NH];
   logic [NH-1:0] m_msip;
   logic [NH-1:0] m_irq;
   logic [NH-1:0] m_nirq;
   bit          started = 0;

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] v, input logic [3:0] m);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = m[i/8] ? v[i] : o[i];
      return r;
   endfunction

   function automatic logic [31:0] mread(input logic [31:0] a, input logic s);
      int off;
      off = int'(a[15:0]) & 32'hFFFC;
      if (!s) return 32'h0;
      if (off == 32'hBFF8) return m_mtime[31:0];
      if (off == 32'hBFFC) return m_mtime[63:32];
      for (int h = 0; h < NH; h++) begin
         if (off == 4 * h)             return {31'b0, m_msip[h]};
         if (off == 32'h4000 + 8 * h)  return m_cmp[h][31:0];
         if (off == 32'h4004 + 8 * h)  return m_cmp[h][63:32];
      end
      return 32'h0;
   endfunction

   always @(posedge clk) begin
      int  off;
      bit  wr;
      bit  tk;
      if (reset) begin
         m_mtime = '0;
         m_presc = 0;
         for (int h = 0; h < NH; h++) m_cmp[h] = '1;
         m_msip  = '0;
         m_irq   = '0;
         started = 1;
      end else begin
         for (int h = 0; h < NH; h++) m_nirq[h] = (m_mtime >= m_cmp[h]);
         off = int'(address_in[15:0]) & 32'hFFFC;
         wr  = sel_in && (write_mask_in != 4'b0);
         tk  = (m_presc == DIV - 1);
         if (wr && off == 32'hBFF8) begin
            m_mtime[31:0] = merge(m_mtime[31:0], write_value_in, write_mask_in);
            m_presc = 0;
         end else if (wr && off == 32'hBFFC) begin
            m_mtime[63:32] = merge(m_mtime[63:32], write_value_in, write_mask_in);
            m_presc = 0;
         end else begin
            if (tk) m_mtime = m_mtime + 64'd1;
            m_presc = tk ? 0 : m_presc + 1;
         end
         for (int h = 0; h < NH; h++) begin
            if (wr && off == 32'h4000 + 8 * h)
               m_cmp[h][31:0] = merge(m_cmp[h][31:0], write_value_in, write_mask_in);
            if (wr && off == 32'h4004 + 8 * h)
               m_cmp[h][63:32] = merge(m_cmp[h][63:32], write_value_in, write_mask_in);
            if (wr && off == 4 * h && write_mask_in[0])
               m_msip[h] = write_value_in[0];
         end
         m_irq = m_nirq;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      asserts++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("model_timer_irq", 64'(timer_irq_out), 64'(m_irq));
         chk("model_soft_irq", 64'(soft_irq_out), 64'(m_msip));
         chk("model_read", 64'(read_value_out), 64'(mread(address_in, sel_in)));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] v, input logic [3:0] m);
      address_in = a; write_value_in = v; write_mask_in = m; sel_in = 1'b1;
      cyc(1);
      sel_in = 1'b0; write_mask_in = 4'h0;
   endtask

   task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
      address_in = a; sel_in = 1'b1; read_in = 1'b1; write_mask_in = 4'h0;
      #1;
      chk(name, 64'(read_value_out), 64'(exp));
      sel_in = 1'b0; read_in = 1'b0;
   endtask

   task automatic do_reset();
      sel_in = 1'b0; write_mask_in = 4'h0; reset = 1'b1;
      cyc(2);
      reset = 1'b0;
   endtask

   initial begin
      bit hit;
      do_reset();
      // Reset state and free-running count
      read_chk("rst_mtime_lo", 32'hBFF8, 32'h0);
      read_chk("rst_mtime_hi", 32'hBFFC, 32'h0);
      read_chk("rst_cmp0_lo", 32'h4000, 32'hFFFF_FFFF);
      chk("rst_timer_irq", 64'(timer_irq_out), 64'h0);
      cyc(40);
      read_chk("mtime_after_40", 32'hBFF8, 32'd10);

      // Hart 1 compare at 20
      do_reset();
      bus_write(32'h400C, 32'h0, 4'hF);
      bus_write(32'h4008, 32'd20, 4'hF);
      address_in = 32'hBFF8; sel_in = 1'b1;
      hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
         cyc(1);
         if (read_value_out == 32'd20) hit = 1;
      end
      sel_in = 1'b0;
      chk("poll_mtime_20_reached", 64'(hit), 64'h1);
      chk("irq_before_latency", 64'(timer_irq_out), 64'h0);
      cyc(1);
      chk("irq_hart1_at_20", 64'(timer_irq_out), 64'h2);

      // Raising mtimecmp[1] drops the irq one cycle after the write
      bus_write(32'h400C, 32'h1, 4'hF);
      chk("irq_still_high_at_write", 64'(timer_irq_out[1]), 64'h1);
      cyc(1);
      chk("irq_dropped", 64'(timer_irq_out[1]), 64'h0);

      // msip lane handling
      bus_write(32'h0000, 32'h1, 4'h1);
      chk("msip_set", 64'(soft_irq_out), 64'h1);
      bus_write(32'h0000, 32'hFFFF_FFFE, 4'hF);
      chk("msip_bit0_only", 64'(soft_irq_out), 64'h0);
      bus_write(32'h0000, 32'h1, 4'h2);
      chk("msip_lane0_disabled", 64'(soft_irq_out), 64'h0);
      bus_write(32'h0000, 32'h1, 4'h1);
      chk("msip_set_again", 64'(soft_irq_out), 64'h1);
      read_chk("msip0_read", 32'h0000, 32'h1);
      read_chk("msip1_read", 32'h0004, 32'h0);
      read_chk("msip_hart2_unmapped", 32'h0008, 32'h0);
      read_chk("cmp_hart2_unmapped", 32'h4010, 32'h0);

      // Carry across halves
      bus_write(32'hBFFC, 32'h0, 4'hF);
      bus_write(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
      cyc(3);
      read_chk("carry_pre_lo", 32'hBFF8, 32'hFFFF_FFFF);
      cyc(1);
      read_chk("carry_hi", 32'hBFFC, 32'h1);
      read_chk("carry_lo", 32'hBFF8, 32'h0);

      // Write in a tick cycle: partial lane write wins, increment lost
      cyc(3);
      bus_write(32'hBFF8, 32'hAAAA_AA55, 4'h1);
      read_chk("tick_write_lo", 32'hBFF8, 32'h55);
      read_chk("tick_write_hi", 32'hBFFC, 32'h1);
      cyc(3);
      read_chk("presc_cleared", 32'hBFF8, 32'h55);
      cyc(1);
      read_chk("post_clear_tick", 32'hBFF8, 32'h56);

      // 64-bit wrap
      bus_write(32'hBFFC, 32'hFFFF_FFFF, 4'hF);
      bus_write(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
      cyc(4);
      read_chk("wrap_lo", 32'hBFF8, 32'h0);
      read_chk("wrap_hi", 32'hBFFC, 32'h0);
      address_in = 32'hBFF8; sel_in = 1'b0;
      #1;
      chk("sel_low_read", 64'(read_value_out), 64'h0);

      // Reset mid-count with irq high and a concurrent write
      bus_write(32'hBFFC, 32'h0, 4'hF);
      bus_write(32'hBFF8, 32'h1234, 4'hF);
      bus_write(32'h4000, 32'h0, 4'hF);
      bus_write(32'h4004, 32'h0, 4'hF);
      cyc(1);
      chk("irq0_before_reset", 64'(timer_irq_out), 64'h1);
      address_in = 32'hBFF8; write_value_in = 32'h55; write_mask_in = 4'hF;
      sel_in = 1'b1; reset = 1'b1;
      cyc(1);
      sel_in = 1'b0; write_mask_in = 4'h0;
      chk("reset_timer_irq", 64'(timer_irq_out), 64'h0);
      chk("reset_soft_irq", 64'(soft_irq_out), 64'h0);
      read_chk("reset_mtime_lo", 32'hBFF8, 32'h0);
      read_chk("reset_cmp0_hi", 32'h4004, 32'hFFFF_FFFF);
      read_chk("read_c000", 32'hC000, 32'h0);
      reset = 1'b0;
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule

// File: doc/clint.md
CLINT -- requirements
Module: clint

Interface
REQ-001 Parameter NUM_HARTS, default 1, number of timer-compare/software-interrupt channels (1..32).
REQ-002 Parameter DIVIDER, default 1, clk cycles per mtime tick (1..65536).
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 address_in  input  32  bus byte address; only [15:2] decoded.
REQ-006 sel_in  input  1  block selected this cycle.
REQ-007 read_in  input  1  read strobe (informational; reads are combinational on sel_in).
REQ-008 read_value_out  output  32  read data, combinational from address and current registers.
REQ-009 write_mask_in  input  4  byte-lane write enables; lane n = bits [8n+7:8n].
REQ-010 write_value_in  input  32  write data.
REQ-011 timer_irq_out  output  NUM_HARTS  registered per-hart machine timer interrupt.
REQ-012 soft_irq_out  output  NUM_HARTS  per-hart machine software interrupt, equal to msip[h].

Function
REQ-013 Address map (offset = address_in[15:0]): msip[h] at 0x0000+4h; mtimecmp[h] low at 0x4000+8h, high at 0x4004+8h; mtime low at 0xBFF8, high at 0xBFFC.
REQ-014 Reads: msip word = {31'b0, msip[h]}; unmapped offsets, h >= NUM_HARTS, or sel_in low -> 0.
REQ-015 Writes occur when sel_in high and write_mask_in nonzero; only enabled byte lanes change; unmapped writes ignored.
REQ-016 msip[h] written from bit 0 only when lane 0 enabled; bits [31:1] ignored.
REQ-017 Prescaler counts 0..DIVIDER-1; tick asserted the cycle it equals DIVIDER-1, then wraps to 0; DIVIDER=1 ticks every cycle.
REQ-018 On tick, mtime <= mtime+1, 64-bit, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0; carry from low to high half in the same cycle.
REQ-019 Write to either mtime half in a tick cycle: write wins; written bytes take write data, unwritten bytes of that 64-bit value keep pre-increment value; increment is lost.
REQ-020 Any mtime write clears the prescaler to 0.
REQ-021 Each cycle timer_irq_out[h] <= (mtime >= mtimecmp[h]), unsigned 64-bit, using current register values (one-cycle latency after any register change).
REQ-022 Comparison level-sensitive: irq remains high until mtimecmp raised above mtime or mtime wraps below it.
REQ-023 Simultaneous mtimecmp write and tick: both take effect; compare next cycle uses both new values.

Reset
REQ-024 On reset: mtime = 0, prescaler = 0, every mtimecmp[h] = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0, timer_irq_out = 0, soft_irq_out = 0.
REQ-025 Reset overrides any concurrent bus write or tick; first tick occurs DIVIDER cycles after reset deasserts.

Structure
REQ-026 Package clint_pkg holds address offsets (MSIP_BASE, MTIMECMP_BASE, MTIME_OFFSET) and the mtimecmp reset constant.
REQ-027 Sub-module clint_prescaler (parameter DIVIDER; inputs clk, reset, clear; output tick) implements REQ-017/020.
REQ-028 Per-hart mtimecmp/compare logic generated via a generate loop over NUM_HARTS.

Verification
REQ-029 NUM_HARTS=2, DIVIDER=4: after reset, mtime reads 0 and timer_irq_out=0; after 40 cycles mtime low reads 10.
REQ-030 Write mtime low 0xFFFF_FFFF mask 0xF, high 0 -> one tick later mtime high=1, low=0.
REQ-031 mtimecmp[1]=20, mtimecmp[0] untouched -> timer_irq_out=2'b10 exactly one cycle after mtime reaches 20; hart 0 stays 0.
REQ-032 With irq[1] high, write mtimecmp[1] high=1 -> timer_irq_out[1] drops one cycle after the write.
REQ-033 Write msip[0] with value 0xFFFF_FFFE mask 0xF -> msip[0]=0; value 1 mask 0x2 -> unchanged; value 1 mask 0x1 -> soft_irq_out[0]=1 next cycle.
REQ-034 Assert reset mid-count with mtime=0x1234 and irq high -> next cycle all state equals REQ-024 values; reads of 0xC000 return 0.
